// File: rtl/conv_line_feeder_pkg.sv
// conv_line_feeder_pkg: shared state type, stride constants and address helpers
package conv_line_feeder_pkg;

    typedef enum logic [2:0] {IDLE, FILL, READY, REFILL, DONE} state_t;

    localparam logic [1:0] STRIDE_1 = 2'd1;
    localparam logic [1:0] STRIDE_2 = 2'd2;

    function automatic logic [1:0] sanitize_stride(input logic [1:0] s);
        return (s == STRIDE_2) ? STRIDE_2 : STRIDE_1;
    endfunction

    function automatic logic [15:0] row_addr(input logic [15:0] base, row, col, img_w);
        return base + row * img_w + col;
    endfunction

    function automatic logic [1:0] mod3(input logic [2:0] v);
        return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
    endfunction

endpackage

// File: rtl/conv_line_feeder_if.sv
// conv_line_feeder_if: source-memory and convolver-side signals of the line feeder
interface conv_line_feeder_if #(
    parameter int BIT_DEPTH = 8,
    parameter int ADDR_W    = 10
);
    logic                 start;
    logic [1:0]           stride;
    logic [ADDR_W-1:0]    base_addr;
    logic                 src_rd_en;
    logic [ADDR_W-1:0]    src_addr;
    logic [BIT_DEPTH-1:0] src_data;
    logic                 shift_buffer;
    logic                 row_advance;
    logic [BIT_DEPTH-1:0] in_l1;
    logic [BIT_DEPTH-1:0] in_l2;
    logic [BIT_DEPTH-1:0] in_l3;
    logic                 ready;
    logic                 frame_done;
    logic                 err;

    modport master (
        output start, stride, base_addr, src_data, shift_buffer, row_advance,
        input  src_rd_en, src_addr, in_l1, in_l2, in_l3, ready, frame_done, err
    );

    modport slave (
        input  start, stride, base_addr, src_data, shift_buffer, row_advance,
        output src_rd_en, src_addr, in_l1, in_l2, in_l3, ready, frame_done, err
    );
endinterface

// File: rtl/conv_line_feeder_row_bank.sv
// row_bank: one image row held in registers, one write port and one combinational read port
module row_bank #(
    parameter int BIT_DEPTH = 8,
    parameter int IMG_W     = 28
) (
    input  logic                       clk,
    input  logic                       i_we,
    input  logic [$clog2(IMG_W)-1:0]   i_waddr,
    input  logic [BIT_DEPTH-1:0]       i_wdata,
    input  logic [$clog2(IMG_W)-1:0]   i_raddr,
    output logic [BIT_DEPTH-1:0]       o_rdata
);
    logic [BIT_DEPTH-1:0] r_mem [IMG_W];

    // pixel storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/conv_line_feeder.sv
// conv_line_feeder: fetches a three-row band from source memory and streams it column by column
module conv_line_feeder
    import conv_line_feeder_pkg::*;
#(
    parameter int BIT_DEPTH = 8,
    parameter int IMG_W     = 28,
    parameter int IMG_H     = 28,
    parameter int ADDR_W    = 10
) (
    input logic               clk,
    input logic               rst_n,
    conv_line_feeder_if.slave bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H) + 2;

    state_t               r_state, w_next;
    logic [1:0]           r_stride, r_top, r_frow, r_nrows, r_wrow, w_wbank;
    logic [ADDR_W-1:0]    r_base;
    logic [RW-1:0]        r_rb, r_fb, w_rb_next;
    logic [CW-1:0]        r_col_ptr, r_fcol, r_wcol;
    logic                 r_wv, r_wlast, r_err;
    logic                 w_fetch, w_last, w_end, w_done_fetch, w_ready, w_start;
    logic [BIT_DEPTH-1:0] w_rd [3];

    assign w_ready      = r_state == READY;
    assign w_start      = r_state == IDLE && bus.start;
    assign w_fetch      = (r_state == FILL || r_state == REFILL) && r_frow < r_nrows;
    assign w_last       = w_fetch && r_frow == r_nrows - 2'd1 && r_fcol == CW'(IMG_W - 1);
    assign w_rb_next    = r_rb + RW'(r_stride);
    assign w_end        = (w_rb_next + RW'(2)) > RW'(IMG_H - 1);
    assign w_done_fetch = r_wv && r_wlast;
    assign w_wbank      = mod3(3'(r_top) + 3'(r_wrow));

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:         w_next = bus.start ? FILL : IDLE;
            FILL, REFILL: w_next = w_done_fetch ? READY : r_state;
            READY:        w_next = bus.row_advance ? (w_end ? DONE : REFILL) : READY;
            default:      w_next = IDLE;
        endcase
    end

    // outputs: read strobe/address follow the fetch counters, pixels come straight from the banks
    always_comb begin
        bus.ready      = w_ready;
        bus.frame_done = r_state == DONE;
        bus.err        = r_err;
        bus.src_rd_en  = w_fetch;
        bus.src_addr   = w_fetch ? ADDR_W'(row_addr(16'(r_base), 16'(r_fb + RW'(r_frow)), 16'(r_fcol), 16'(IMG_W))) : '0;
        bus.in_l1      = w_ready ? w_rd[r_top] : '0;
        bus.in_l2      = w_ready ? w_rd[mod3(3'(r_top) + 3'd1)] : '0;
        bus.in_l3      = w_ready ? w_rd[mod3(3'(r_top) + 3'd2)] : '0;
    end

    // fetch counters, one-cycle write pipeline matching memory latency, column pointer, band rotation, error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stride  <= STRIDE_1;
            r_base    <= '0;
            r_rb      <= '0;
            r_fb      <= '0;
            r_top     <= '0;
            r_frow    <= '0;
            r_fcol    <= '0;
            r_nrows   <= '0;
            r_col_ptr <= '0;
            r_wv      <= 1'b0;
            r_wlast   <= 1'b0;
            r_wrow    <= '0;
            r_wcol    <= '0;
            r_err     <= 1'b0;
        end else begin
            r_wv    <= w_fetch;
            r_wlast <= w_last;
            r_wrow  <= r_frow;
            r_wcol  <= r_fcol;
            if (w_fetch) begin
                r_fcol <= (r_fcol == CW'(IMG_W - 1)) ? '0 : r_fcol + 1'b1;
                r_frow <= (r_fcol == CW'(IMG_W - 1)) ? r_frow + 2'd1 : r_frow;
            end
            if (w_start) begin
                r_stride  <= sanitize_stride(bus.stride);
                r_base    <= bus.base_addr;
                r_rb      <= '0;
                r_fb      <= '0;
                r_top     <= '0;
                r_frow    <= '0;
                r_fcol    <= '0;
                r_nrows   <= 2'd3;
                r_col_ptr <= '0;
            end
            if (w_ready && bus.row_advance) begin
                r_col_ptr <= '0;
                r_rb      <= w_rb_next;
                r_fb      <= r_rb + RW'(3);
                r_frow    <= '0;
                r_fcol    <= '0;
                r_nrows   <= r_stride;
            end else if (w_ready && bus.shift_buffer) begin
                r_col_ptr <= (r_col_ptr == CW'(IMG_W - 1)) ? '0 : r_col_ptr + 1'b1;
            end
            if (w_done_fetch) r_top <= mod3(3'(r_top) + 3'(r_nrows));
            r_err <= (w_start ? 1'b0 : r_err) | (!w_ready && (bus.shift_buffer || bus.row_advance));
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_bank
        row_bank #(.BIT_DEPTH(BIT_DEPTH), .IMG_W(IMG_W)) u_bank (
            .clk     (clk),
            .i_we    (r_wv && w_wbank == 2'(g)),
            .i_waddr (r_wcol),
            .i_wdata (bus.src_data),
            .i_raddr (r_col_ptr),
            .o_rdata (w_rd[g])
        );
    end
endmodule

// File: doc/conv_line_feeder.md
Name: conv_line_feeder

Overview:
- Source-side responder to the convolution engine's line-buffer interface: answers `shift_buffer` requests by presenting one pixel column from three consecutive image rows on `in_l1`/`in_l2`/`in_l3`.
- Fetches rows from a single-port source image memory (1-cycle read latency) into three row banks.
- Advances the row band by `stride` on request and reports frame completion.
- Sits between the source feature-map RAM and the convolver.

Parameters:
- BIT_DEPTH, 8, pixel width.
- IMG_W, 28, image width in pixels.
- IMG_H, 28, image height in rows.
- ADDR_W, 10, source memory address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a frame; sampled only in IDLE.
- stride  in  2  row/column stride; only 1 and 2 valid; 0 or 3 treated as 1.
- base_addr  in  ADDR_W  source address of pixel (0,0).
- src_rd_en  out  1  source memory read strobe.
- src_addr  out  ADDR_W  source memory read address.
- src_data  in  BIT_DEPTH  read data, valid the cycle after src_rd_en.
- shift_buffer  in  1  convolver column request, one column per high cycle.
- row_advance  in  1  single-cycle pulse: move band down by stride.
- in_l1  out  BIT_DEPTH  band top row pixel at current column.
- in_l2  out  BIT_DEPTH  band middle row pixel.
- in_l3  out  BIT_DEPTH  band bottom row pixel.
- ready  out  1  band loaded; shift_buffer is honoured.
- frame_done  out  1  one-cycle pulse when the frame is exhausted.
- err  out  1  sticky protocol error; cleared by start or reset.

Behaviour:
- Reset values (rst_n low, asynchronous): state=IDLE; src_rd_en=0; src_addr=0; ready=0; frame_done=0; err=0; col_ptr=0; top=0; row_base=0; in_l1..3=0. Bank contents are not reset.
- States: IDLE, FILL, READY, REFILL, DONE.
- IDLE:
  - start=1 latches stride (sanitised to stride_q) and base_addr.
  - Clears err, row_base=0, top=0, then goes to FILL.
- FILL:
  - Issues 3*IMG_W consecutive reads, one per cycle: rows 0..2, columns 0..IMG_W-1, src_addr = base_addr + row*IMG_W + col.
  - Each returned byte is written to bank[(top+r)%3][col] one cycle after its read.
  - Goes to READY the cycle after the last write lands. Fill latency = 3*IMG_W+1 cycles from the FILL entry edge.
- READY:
  - ready=1. Outputs are combinational reads: in_l1=bank[top][col_ptr], in_l2=bank[(top+1)%3][col_ptr], in_l3=bank[(top+2)%3][col_ptr].
  - The value shown while shift_buffer=1 is the one consumed at that edge.
  - Each cycle with shift_buffer=1: col_ptr+1; at IMG_W-1 it wraps to 0.
- row_advance in READY:
  - col_ptr<=0, ready<=0, row_base<=row_base+stride_q.
  - If row_base+stride_q+2 > IMG_H-1: go to DONE.
  - Otherwise go to REFILL.
- REFILL:
  - Fetches stride_q new rows, (row_base_new+3-stride_q)..(row_base_new+2).
  - Writes them into banks top .. top+stride_q-1 (mod 3); then top<=(top+stride_q)%3 and return to READY.
  - Latency = stride_q*IMG_W+1 cycles.
- DONE: frame_done=1 for exactly one cycle, ready=0, then IDLE.
- Boundary cases:
  - shift_buffer while ready=0: ignored, err<=1.
  - row_advance outside READY: ignored, err<=1.
  - shift_buffer and row_advance in the same READY cycle: row_advance wins; col_ptr<=0.
  - start outside IDLE: ignored, no error.
  - rst_n low mid-fetch: immediate return to reset values; the in-flight read is discarded.
- Address arithmetic is ADDR_W wide and wraps modulo 2^ADDR_W; the caller ensures base_addr + IMG_W*IMG_H fits.
- Bank write data is exactly BIT_DEPTH bits; no arithmetic is applied to pixels.

Decomposition:
- Shared package holds:
  - state enum (IDLE..DONE);
  - STRIDE_1/STRIDE_2 constants;
  - a function sanitising stride;
  - function row_addr(base,row,col).
- One sub-module, `row_bank`: IMG_W x BIT_DEPTH register array with one write port and one combinational read port, instantiated three times.
- FSM, fetch counter and bank rotation stay in the top module.

Test Plan:
- Fill: memory pixel(r,c)=(r*IMG_W+c) mod 256, stride=1, start → ready rises 85 cycles after FILL entry; first outputs in_l1/2/3 = 0, 28, 56.
- Column stream: 28 consecutive shift_buffer cycles → cycle k shows k, 28+k, 56+k; after the 28th, col_ptr wraps and shows 0, 28, 56.
- Stride 2 advance: stride=2, row_advance after fill → REFILL takes 57 cycles; then in_l1/2/3 at col 0 = 56, 84, 112 (mod 256).
- Frame end: stride=1, 25 row_advance pulses → the 26th pulse (row_base 26, 26+2>27) gives one frame_done pulse, then IDLE, ready=0.
- Protocol error: shift_buffer during FILL → err=1, col_ptr stays 0 after ready; next start clears err.
- Reset mid-REFILL: rst_n low for 1 cycle → src_rd_en=0, ready=0, state=IDLE immediately; new start refills correctly.
